mips_single_cycle: RTL and testbench

- Single-cycle 32-bit MIPS processor; the top-level CPU of the design, with only clock and reset as ports.
- Contains PC, instruction memory (IM), 32x32 general register file (GRF), ALU, data memory (DM) and control decode.
- Every instruction fetches, executes and commits in exactly one clock cycle.
- Architectural state is observed through hierarchical access and the optional write trace.

---
 rtl/mips_single_cycle_pkg.sv | 35 +++
 rtl/mips_single_cycle_if.sv | 19 +
 rtl/mips_single_cycle_grf.sv | 37 +++
 rtl/mips_single_cycle.sv | 139 +++++++++++++
 tb/tb_mips_single_cycle.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_single_cycle_pkg.sv
// mips_pkg: shared constants and types for the single-cycle MIPS core.
//   - opcode / funct encodings of the supported instructions
//   - ALU operation and register-destination select enums
//   - default reset PC and the ALU evaluation helper
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI} alu_op_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_e;

  // Wrap-around arithmetic; lui places the low half of b in the upper half.
  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: alu_eval = a + b;
      ALU_SUB: alu_eval = a - b;
      ALU_OR:  alu_eval = a | b;
      default: alu_eval = {b[15:0], 16'h0000};
    endcase
  endfunction

endpackage

// File: rtl/mips_single_cycle_if.sv
// mips_grf_if: register-file access bus between the core and mips_grf.
//   ra1/ra2 -> rd1/rd2 : two combinational read ports
//   we/wa/wd           : one write port, committed on the rising edge
//   pc                 : PC of the instruction owning the write (trace only)
// There is no handshake: a write presented with we=1 always commits on the
// next rising edge unless reset is high.
interface mips_grf_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pc;

  modport master (output ra1, ra2, we, wa, wd, pc, input rd1, rd2);
  modport slave  (input ra1, ra2, we, wa, wd, pc, output rd1, rd2);
endinterface

// File: rtl/mips_single_cycle_grf.sv
// mips_grf: 32x32 general register file.
//   clk, reset : synchronous active-high reset clears all registers
//   bus        : mips_grf_if slave (2 async reads, 1 sync write)
// $0 reads as zero and ignores writes. A read of the register being written
// returns the old value (write lands on the edge).
// Optional: MIPS_TRACE_EN prints every enabled write, including to $0.
module mips_grf
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mips_grf_if.slave bus
);

  logic [31:0] r_regs [32];

  assign bus.rd1 = (bus.ra1 == 5'd0) ? 32'h0 : r_regs[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 5'd0) ? 32'h0 : r_regs[bus.ra2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else if (bus.we && (bus.wa != 5'd0)) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

`ifdef MIPS_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && bus.we) $display("@%h: $%d <= %h", bus.pc, bus.wa, bus.wd);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.pc;
`endif

endmodule

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle 32-bit MIPS core (addu, subu, ori, lui,
// lw, sw, beq, j, jal, jr; everything else behaves as nop).
//   clk   : all state (PC, GRF, DM) commits on the rising edge
//   reset : synchronous active-high; PC <= PC_RESET, GRF and DM cleared,
//           IM untouched
// IM contents are provided by the environment (hierarchical image of r_im).
// Optional: MIPS_TRACE_EN prints GRF and DM writes.
module mips_single_cycle
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT,
  parameter int          IM_WORDS     = 1024,
  parameter int          DM_WORDS     = 1024,
  parameter string       IM_INIT_FILE = "code.txt"
) (
  input logic clk,
  input logic reset
);

  localparam int IM_AW = $clog2(IM_WORDS);
  localparam int DM_AW = $clog2(DM_WORDS);

  logic [31:0] r_pc;
  logic [31:0] r_im [IM_WORDS];
  logic [31:0] r_dm [DM_WORDS];

  mips_grf_if grf_bus ();

  mips_grf u_grf (
    .clk   (clk),
    .reset (reset),
    .bus   (grf_bus.slave)
  );

  // Fetch: word index relative to PC_RESET, wrapping over IM depth.
  logic [31:0] w_pc_off, w_instr, w_pc_plus4;
  assign w_pc_off   = r_pc - PC_RESET;
  assign w_instr    = r_im[w_pc_off[IM_AW+1:2]];
  assign w_pc_plus4 = r_pc + 32'd4;

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  assign w_opcode = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];

  // Decode
  logic     w_reg_we, w_dm_we, w_b_imm, w_imm_zext, w_mem_to_reg, w_link;
  logic     w_is_beq, w_is_j, w_is_jr;
  alu_op_e  w_alu_op;
  dst_sel_e w_dst;

  always_comb begin
    w_reg_we = 1'b0; w_dm_we = 1'b0; w_b_imm = 1'b0; w_imm_zext = 1'b0;
    w_mem_to_reg = 1'b0; w_link = 1'b0;
    w_is_beq = 1'b0; w_is_j = 1'b0; w_is_jr = 1'b0;
    w_alu_op = ALU_ADD; w_dst = DST_RT;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: begin w_reg_we = 1'b1; w_dst = DST_RD; w_alu_op = ALU_ADD; end
          FN_SUBU: begin w_reg_we = 1'b1; w_dst = DST_RD; w_alu_op = ALU_SUB; end
          FN_JR:   w_is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ORI: begin w_reg_we = 1'b1; w_alu_op = ALU_OR; w_b_imm = 1'b1; w_imm_zext = 1'b1; end
      OP_LUI: begin w_reg_we = 1'b1; w_alu_op = ALU_LUI; w_b_imm = 1'b1; end
      OP_LW:  begin w_reg_we = 1'b1; w_b_imm = 1'b1; w_mem_to_reg = 1'b1; end
      OP_SW:  begin w_dm_we = 1'b1; w_b_imm = 1'b1; end
      OP_BEQ: w_is_beq = 1'b1;
      OP_J:   w_is_j = 1'b1;
      OP_JAL: begin w_is_j = 1'b1; w_reg_we = 1'b1; w_dst = DST_RA; w_link = 1'b1; end
      default: ;
    endcase
  end

  // Execute
  logic [31:0] w_imm_ext, w_alu_b, w_alu_y, w_dm_rd;
  logic [DM_AW-1:0] w_dm_idx;
  assign w_imm_ext = w_imm_zext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};
  assign grf_bus.ra1 = w_rs;
  assign grf_bus.ra2 = w_rt;
  assign w_alu_b  = w_b_imm ? w_imm_ext : grf_bus.rd2;
  assign w_alu_y  = alu_eval(w_alu_op, grf_bus.rd1, w_alu_b);
  assign w_dm_idx = w_alu_y[DM_AW+1:2];
  assign w_dm_rd  = r_dm[w_dm_idx];

  // Writeback
  always_comb begin
    case (w_dst)
      DST_RD:  grf_bus.wa = w_rd;
      DST_RA:  grf_bus.wa = 5'd31;
      default: grf_bus.wa = w_rt;
    endcase
  end
  assign grf_bus.we = w_reg_we;
  assign grf_bus.wd = w_link ? w_pc_plus4 : (w_mem_to_reg ? w_dm_rd : w_alu_y);
  assign grf_bus.pc = r_pc;

  // Next PC
  logic [31:0] w_pc_next;
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_is_jr)
      w_pc_next = grf_bus.rd1;
    else if (w_is_j)
      w_pc_next = {r_pc[31:28], w_instr[25:0], 2'b00};
    else if (w_is_beq && (grf_bus.rd1 == grf_bus.rd2))
      w_pc_next = w_pc_plus4 + {w_imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PC_RESET;
      for (int i = 0; i < DM_WORDS; i++) r_dm[i] <= 32'h0;
    end else begin
      r_pc <= w_pc_next;
      if (w_dm_we) r_dm[w_dm_idx] <= grf_bus.rd2;
    end
  end

`ifdef MIPS_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_dm_we)
      $display("@%h: *%h <= %h", r_pc, {w_alu_y[31:2], 2'b00}, grf_bus.rd2);
  end
`endif

  // Address bits that fall outside the memory depths are don't-care.
  logic w_unused;
  assign w_unused = ^{w_pc_off[31:IM_AW+2], w_pc_off[1:0],
                      w_alu_y[31:DM_AW+2], w_alu_y[1:0], w_instr[10:6]};

endmodule

// File: tb/tb_mips_single_cycle.sv
module tb_mips_single_cycle;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_single_cycle #(.IM_INIT_FILE("")) dut (.clk(clk), .reset(reset));

  // Monitor copy of the register-file bus
  mips_grf_if mon_if ();
  assign mon_if.ra1 = dut.grf_bus.ra1;
  assign mon_if.ra2 = dut.grf_bus.ra2;
  assign mon_if.rd1 = dut.grf_bus.rd1;
  assign mon_if.rd2 = dut.grf_bus.rd2;
  assign mon_if.we  = dut.grf_bus.we;
  assign mon_if.wa  = dut.grf_bus.wa;
  assign mon_if.wd  = dut.grf_bus.wd;
  assign mon_if.pc  = dut.grf_bus.pc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    enc_r = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    enc_i = {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] idx);
    enc_j = {op, idx};
  endfunction

  logic [31:0] im_img[$];

  task automatic load_im();
    for (int i = 0; i < 64; i++)
      dut.r_im[i] = (i < im_img.size()) ? im_img[i] : 32'h0;
  endtask

  function automatic logic [31:0] grf_or();
    logic [31:0] acc = 32'h0;
    for (int k = 0; k < 32; k++) acc |= dut.u_grf.r_regs[k];
    return acc;
  endfunction
  function automatic logic [31:0] dm_or();
    logic [31:0] acc = 32'h0;
    for (int k = 0; k < 1024; k++) acc |= dut.r_dm[k];
    return acc;
  endfunction

  // Reference model: instruction-level interpreter over program descriptors
  typedef struct {
    int kind;            // 0 addu 1 subu 2 ori 3 lui 4 sw 5 lw 6 beq(+1)
    int rs; int rt; int rd;
    logic [15:0] imm;
  } ins_t;

  ins_t prog[$];
  logic [31:0] m_reg[32];
  logic [31:0] m_dm[16];
  int m_cycles;

  function automatic logic [31:0] encode(ins_t x);
    case (x.kind)
      0: return enc_r(x.rs, x.rt, x.rd, 6'h21);
      1: return enc_r(x.rs, x.rt, x.rd, 6'h23);
      2: return enc_i(6'h0d, x.rs, x.rt, x.imm);
      3: return enc_i(6'h0f, x.rs, x.rt, x.imm);
      4: return enc_i(6'h2b, x.rs, x.rt, x.imm);
      5: return enc_i(6'h23, x.rs, x.rt, x.imm);
      default: return enc_i(6'h04, x.rs, x.rt, 16'h0001);
    endcase
  endfunction

  task automatic gen_random(input int n);
    ins_t x;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      x.kind = $urandom_range(0, 6);
      if (x.kind == 6 && i > n - 2) x.kind = 0;
      x.rs = $urandom_range(0, 7);
      x.rt = $urandom_range(0, 7);
      x.rd = $urandom_range(0, 7);
      x.imm = 16'($urandom_range(0, 16'hffff));
      if (x.kind == 4 || x.kind == 5) begin
        x.rs  = 0;
        x.imm = 16'(4 * $urandom_range(0, 15));
      end
      prog.push_back(x);
    end
    im_img.delete();
    foreach (prog[i]) im_img.push_back(encode(prog[i]));
    im_img.push_back(enc_i(6'h04, 0, 0, 16'hffff));
  endtask

  task automatic run_model();
    int ip = 0;
    ins_t x;
    foreach (m_reg[k]) m_reg[k] = 32'h0;
    foreach (m_dm[k]) m_dm[k] = 32'h0;
    m_cycles = 0;
    while (ip < prog.size()) begin
      x = prog[ip];
      ip++;
      m_cycles++;
      case (x.kind)
        0: if (x.rd != 0) m_reg[x.rd] = m_reg[x.rs] + m_reg[x.rt];
        1: if (x.rd != 0) m_reg[x.rd] = m_reg[x.rs] - m_reg[x.rt];
        2: if (x.rt != 0) m_reg[x.rt] = m_reg[x.rs] | {16'h0, x.imm};
        3: if (x.rt != 0) m_reg[x.rt] = {x.imm, 16'h0};
        4: m_dm[x.imm / 4] = m_reg[x.rt];
        5: if (x.rt != 0) m_reg[x.rt] = m_dm[x.imm / 4];
        default: if (m_reg[x.rs] == m_reg[x.rt]) ip++;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_r%0d", tag, k), dut.u_grf.r_regs[k] & ((k == 0) ? 32'h0 : 32'hffffffff) | ((k == 0) ? mon_zero() : 32'h0), m_reg[k]);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_dm%0d", tag, k), dut.r_dm[k], m_dm[k]);
    check({tag, "_pc"}, dut.r_pc, 32'h3000 + 32'(4 * prog.size()));
  endtask

  // $0 is observed through a read port rather than the storage cell.
  function automatic logic [31:0] mon_zero();
    return (dut.grf_bus.ra1 == 5'd0) ? dut.grf_bus.rd1 : 32'h0;
  endfunction

  initial begin
    // ---------------- reset held 10 cycles ----------------
    im_img = '{enc_i(6'h0d, 0, 1, 16'hffff), enc_i(6'h0f, 0, 2, 16'h8000),
               enc_r(1, 2, 3, 6'h21),         enc_r(0, 1, 4, 6'h23),
               enc_i(6'h0d, 0, 5, 16'h0008),  enc_i(6'h2b, 5, 3, 16'hfffc),
               enc_i(6'h23, 0, 6, 16'h0004),  enc_i(6'h0d, 0, 0, 16'h0005),
               enc_i(6'h04, 1, 2, 16'h0001),  enc_i(6'h04, 0, 0, 16'hffff)};
    load_im();
    step(10);
    check("reset_pc", dut.r_pc, 32'h3000);
    check("reset_grf", grf_or(), 32'h0);
    check("reset_dm", dm_or(), 32'h0);

    // ---------------- arithmetic + memory program ----------------
    reset = 1'b0;
    step(1);
    check("ori_r1", dut.u_grf.r_regs[1], 32'h0000ffff);
    check("pc_1", dut.r_pc, 32'h3004);
    step(6);
    check("zero_we", {31'h0, mon_if.we}, 32'h1);
    check("zero_wa", {27'h0, mon_if.wa}, 32'h0);
    step(2);
    check("lui_r2", dut.u_grf.r_regs[2], 32'h80000000);
    check("addu_r3", dut.u_grf.r_regs[3], 32'h8000ffff);
    check("subu_r4", dut.u_grf.r_regs[4], 32'hffff0001);
    check("ori_r5", dut.u_grf.r_regs[5], 32'h00000008);
    check("sw_dm1", dut.r_dm[1], 32'h8000ffff);
    check("lw_r6", dut.u_grf.r_regs[6], 32'h8000ffff);
    check("r0_cell", dut.u_grf.r_regs[0], 32'h0);
    check("beq_nt_pc", dut.r_pc, 32'h3024);
    step(3);
    check("loop_pc", dut.r_pc, 32'h3024);

    // ---------------- branch program ----------------
    reset = 1'b1;
    im_img = '{enc_i(6'h0d, 0, 1, 16'h0001), enc_i(6'h04, 1, 0, 16'h0005),
               32'h0, 32'h0, enc_i(6'h04, 0, 0, 16'hffff)};
    load_im();
    step(2);
    check("rst2_grf", grf_or(), 32'h0);
    reset = 1'b0;
    step(2);
    check("beq_ne_pc", dut.r_pc, 32'h3008);
    step(2);
    check("beq_at_3010", dut.r_pc, 32'h3010);
    step(3);
    check("beq_taken_pc", dut.r_pc, 32'h3010);

    // ---------------- jump program ----------------
    reset = 1'b1;
    im_img = '{enc_j(6'h03, 26'h0000C02), enc_j(6'h02, 26'h0000C03),
               enc_r(31, 0, 0, 6'h08),      enc_i(6'h04, 0, 0, 16'hffff)};
    load_im();
    step(2);
    reset = 1'b0;
    step(1);
    check("jal_pc", dut.r_pc, 32'h3008);
    check("jal_r31", dut.u_grf.r_regs[31], 32'h3004);
    step(1);
    check("jr_pc", dut.r_pc, 32'h3004);
    step(1);
    check("j_pc", dut.r_pc, 32'h300c);
    step(2);
    check("j_loop_pc", dut.r_pc, 32'h300c);

    // ---------------- random programs vs. model ----------------
    for (int round = 0; round < 3; round++) begin
      reset = 1'b1;
      gen_random(40);
      load_im();
      run_model();
      step(2);
      reset = 1'b0;
      if (round == 2) begin
        // Mid-program reset discards everything done so far.
        step(12);
        reset = 1'b1;
        step(1);
        check("mid_rst_pc", dut.r_pc, 32'h3000);
        check("mid_rst_grf", grf_or(), 32'h0);
        check("mid_rst_dm", dm_or(), 32'h0);
        reset = 1'b0;
      end
      step(m_cycles + 3);
      for (int k = 1; k < 8; k++)
        check($sformatf("rnd%0d_r%0d", round, k), dut.u_grf.r_regs[k], m_reg[k]);
      check($sformatf("rnd%0d_r0", round), dut.u_grf.r_regs[0], 32'h0);
      for (int k = 0; k < 16; k++)
        check($sformatf("rnd%0d_dm%0d", round, k), dut.r_dm[k], m_dm[k]);
      check($sformatf("rnd%0d_pc", round), dut.r_pc, 32'h3000 + 32'(4 * prog.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
